multicycle_control_alu: RTL and testbench
=========================================

Name: multicycle_control_alu

Overview:
Control-and-compute core of the team's multicycle MIPS-subset processor. It merges the multicycle control FSM (Control), the 32-bit ALU (ALU) and the PC adders (adder) into one block. The surrounding datapath owns the PC, IR, register file, memory and operand muxes. This block produces every control strobe, the ALU result and zero flag, PC+4 and the branch target.

Parameters:
none (all widths are fixed at 32-bit data, 5-bit ALUControl and 4-bit state).

Ports:
clock  in  1  system clock; rising edge is active
reset_n  in  1  asynchronous reset, active low
instr  in  32  current IR contents; fields op=[31:26], funct=[5:0], imm=[15:0]
srcA  in  32  ALU operand A, already muxed by the datapath
srcB  in  32  ALU operand B, already muxed by the datapath
pcQ  in  32  current PC register value
ALUResult  out  32  ALU output (combinational)
zero  out  1  high when ALUResult == 0
pcPlus4  out  32  pcQ + 4
pcBranch  out  32  pcQ + (sign-extended imm << 2)
ALUControl  out  5  ALU operation select
memToReg, memWrite, branchEnable, ALUSrc, regDst, regWriteEnable, jump, jumpReg, PCWrite, IorD, IRWrite, ALUSrcA, ALUSrcB  out  1 each  control strobes
pcEnable  out  1  PCWrite | (branchEnable & zero)
state  out  4  current FSM state, for debug

Behaviour:
- Reset: asynchronous assertion sets state to FETCH (0). While reset_n is low, PCWrite, pcEnable, IRWrite, memWrite and regWriteEnable are forced to 0. Reset asserted mid-instruction abandons that instruction.
- Mux encodings:
  - IorD: 0 = PC, 1 = ALUOut.
  - ALUSrcA: 0 = PC, 1 = register A.
  - ALUSrcB: 0 = constant 4, 1 = sign-extended imm.
  - ALUSrc: 1 = register B, and it overrides ALUSrcB.
- Default output value is 0 wherever a state does not list a signal.
- ALUControl codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed, result 1 or 0), 7 SLL (srcA << srcB[4:0]). Codes 8–31 give result 0. Arithmetic wraps mod 2^32 with no overflow flag.
- Adders wrap mod 2^32 and are purely combinational.
- FSM is Moore; every state lasts exactly one clock. States (encoding):
  - FETCH(0): IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=0, ADD, PCWrite=1. Next: DECODE.
  - DECODE(1): no strobes. Next by opcode:
    - lw (0x23) or sw (0x2B) → MEMADR
    - R-type (0x00) with funct 0x08 → JUMPREG
    - other R-type → EXECUTE
    - beq (0x04) → BRANCH
    - addi (0x08) → ADDIEXEC
    - j (0x02) or jal (0x03) → JUMP
    - any other opcode → FETCH
  - MEMADR(2): ALUSrcA=1, ALUSrcB=1, ADD. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD(3): IorD=1. Next: MEMWB.
  - MEMWB(4): regDst=0, memToReg=1, regWriteEnable=1. Next: FETCH.
  - MEMWRITE(5): IorD=1, memWrite=1. Next: FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrc=1. ALUControl from funct:
    - 0x20 → ADD, 0x22 → SUB, 0x24 → AND, 0x25 → OR
    - 0x26 → XOR, 0x27 → NOR, 0x2A → SLT, 0x00 → SLL
    - any other funct → ADD
    - Next: ALUWB.
  - ALUWB(7): regDst=1, regWriteEnable=1. Next: FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrc=1, SUB, branchEnable=1. The PC is loaded from pcBranch via pcEnable when zero=1. Next: FETCH.
  - ADDIEXEC(9): ALUSrcA=1, ALUSrcB=1, ADD. Next: ADDIWB.
  - ADDIWB(10): regDst=0, regWriteEnable=1. Next: FETCH.
  - JUMP(11): jump=1, PCWrite=1. For jal, regWriteEnable=1 as well (the datapath steers this write to r31). Next: FETCH.
  - JUMPREG(12): jumpReg=1, PCWrite=1. Next: FETCH.
  - Codes 13–15 are unreachable; if ever entered, all strobes are 0 and next state is FETCH.
- Instruction latency in cycles:
  - lw 5
  - R-type, addi 4
  - sw 4
  - beq, j, jal, jr 3

Test Plan:
- Reset low mid-MEMADR → state=0 immediately with no clock edge. All write strobes stay 0 until reset_n rises. The first edge after reset_n rises moves the FSM to DECODE.
- instr=0x00221820 (add), srcA=7, srcB=5 → state sequence 0,1,6,7,0. In state 6, ALUResult=12. In state 7, regDst=1 and regWriteEnable=1.
- instr=0x8C220004 (lw) → state sequence 0,1,2,3,4,0. State 2 has ALUSrcB=1. State 3 has IorD=1. State 4 has memToReg=1. Repeat with 0xAC220004 (sw) → sequence 0,1,2,5,0 with memWrite=1 in state 5.
- instr=0x10220003 (beq), pcQ=0x100 → pcPlus4=0x104 and pcBranch=0x10C. With srcA=srcB=9: zero=1 and pcEnable=1 in state 8. With srcA=9, srcB=8: pcEnable=0.
- ALU corners, with an R-type instruction held in EXECUTE:
  - SUB 5−7 → 0xFFFFFFFE
  - SLT 0xFFFFFFFF vs 1 → 1
  - ADD 0xFFFFFFFF+1 → 0 with zero=1
  - NOR 0 with 0 → 0xFFFFFFFF
- instr=0x0C000010 (jal) → sequence 0,1,11,0 with jump=1, PCWrite=1 and regWriteEnable=1. Opcode 0x3F → sequence 0,1,0.

Source files
------------

// File: rtl/multicycle_control_alu_if.sv
// Purpose: bundles the datapath-facing signals of the multicycle control/ALU core.
// Latency: n/a (wiring only); outputs of the core are a mix of registered strobes and combinational ALU/adder results.
// Backpressure: none; the datapath consumes every strobe in the cycle it is presented.
// Ports: instr/srcA/srcB/pcQ flow datapath -> core; ALU result, adders, control strobes and debug state flow core -> datapath.
interface multicycle_control_alu_if;
    logic [31:0] instr;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [31:0] pcQ;
    logic [31:0] ALUResult;
    logic        zero;
    logic [31:0] pcPlus4;
    logic [31:0] pcBranch;
    logic [4:0]  ALUControl;
    logic        memToReg;
    logic        memWrite;
    logic        branchEnable;
    logic        ALUSrc;
    logic        regDst;
    logic        regWriteEnable;
    logic        jump;
    logic        jumpReg;
    logic        PCWrite;
    logic        IorD;
    logic        IRWrite;
    logic        ALUSrcA;
    logic        ALUSrcB;
    logic        pcEnable;
    logic [3:0]  state;

    // Datapath side: drives the instruction and operands, observes the core.
    modport master (
        output instr, srcA, srcB, pcQ,
        input  ALUResult, zero, pcPlus4, pcBranch, ALUControl,
        input  memToReg, memWrite, branchEnable, ALUSrc, regDst, regWriteEnable,
        input  jump, jumpReg, PCWrite, IorD, IRWrite, ALUSrcA, ALUSrcB, pcEnable, state
    );

    // Core side.
    modport slave (
        input  instr, srcA, srcB, pcQ,
        output ALUResult, zero, pcPlus4, pcBranch, ALUControl,
        output memToReg, memWrite, branchEnable, ALUSrc, regDst, regWriteEnable,
        output jump, jumpReg, PCWrite, IorD, IRWrite, ALUSrcA, ALUSrcB, pcEnable, state
    );
endinterface

// File: rtl/multicycle_control_alu.sv
// Purpose: multicycle MIPS-subset control FSM merged with the 32-bit ALU and the PC adders.
// Latency: one state per clock (lw 5, R-type/addi/sw 4, beq/j/jal/jr 3 cycles); ALU and adders are combinational.
// Backpressure: none; the FSM advances every clock and the datapath must follow.
// Ports: clock, reset_n (async, active low), bus (slave modport of multicycle_control_alu_if).
module multicycle_control_alu (
    input  logic                           clock,
    input  logic                           reset_n,
    multicycle_control_alu_if.slave        bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_JUMPREG  = 4'd12
    } state_t;

    typedef struct packed {
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch_enable;
        logic       alu_src;
        logic       reg_dst;
        logic       reg_write_enable;
        logic       jump;
        logic       jump_reg;
        logic       pc_write;
        logic       ior_d;
        logic       ir_write;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [4:0] alu_control;
    } ctrl_t;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_XOR = 5'd4;
    localparam logic [4:0] ALU_NOR = 5'd5;
    localparam logic [4:0] ALU_SLT = 5'd6;
    localparam logic [4:0] ALU_SLL = 5'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        unused_instr;

    assign op           = bus.instr[31:26];
    assign funct        = bus.instr[5:0];
    assign imm          = bus.instr[15:0];
    assign unused_instr = ^bus.instr[25:16];

    function automatic state_t next_of(input state_t s, input logic [5:0] o, input logic [5:0] fn);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:    n = S_DECODE;
            S_DECODE: begin
                case (o)
                    OP_LW, OP_SW: n = S_MEMADR;
                    OP_RTYPE:     n = (fn == FN_JR) ? S_JUMPREG : S_EXECUTE;
                    OP_BEQ:       n = S_BRANCH;
                    OP_ADDI:      n = S_ADDIEXEC;
                    OP_J, OP_JAL: n = S_JUMP;
                    default:      n = S_FETCH;
                endcase
            end
            S_MEMADR:   n = (o == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  n = S_MEMWB;
            S_EXECUTE:  n = S_ALUWB;
            S_ADDIEXEC: n = S_ADDIWB;
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

    function automatic logic [4:0] funct_to_alu(input logic [5:0] fn);
        logic [4:0] a;
        case (fn)
            6'h20:   a = ALU_ADD;
            6'h22:   a = ALU_SUB;
            6'h24:   a = ALU_AND;
            6'h25:   a = ALU_OR;
            6'h26:   a = ALU_XOR;
            6'h27:   a = ALU_NOR;
            6'h2A:   a = ALU_SLT;
            6'h00:   a = ALU_SLL;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    // Strobes for the state being entered; registering them keeps the outputs glitch-free.
    function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] o, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write = 1'b1;
                c.pc_write = 1'b1;
            end
            S_MEMADR, S_ADDIEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 1'b1;
            end
            S_MEMREAD:  c.ior_d = 1'b1;
            S_MEMWB: begin
                c.mem_to_reg       = 1'b1;
                c.reg_write_enable = 1'b1;
            end
            S_MEMWRITE: begin
                c.ior_d     = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a   = 1'b1;
                c.alu_src     = 1'b1;
                c.alu_control = funct_to_alu(fn);
            end
            S_ALUWB: begin
                c.reg_dst          = 1'b1;
                c.reg_write_enable = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src       = 1'b1;
                c.alu_control   = ALU_SUB;
                c.branch_enable = 1'b1;
            end
            S_ADDIWB:   c.reg_write_enable = 1'b1;
            S_JUMP: begin
                c.jump             = 1'b1;
                c.pc_write         = 1'b1;
                // jal links through the register file; the datapath routes it to r31.
                c.reg_write_enable = (o == OP_JAL);
            end
            S_JUMPREG: begin
                c.jump_reg = 1'b1;
                c.pc_write = 1'b1;
            end
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_t      state_q;
    state_t      state_d;
    ctrl_t       ctrl_q;
    logic [31:0] alu_result;

    always_comb begin
        state_d = next_of(state_q, op, funct);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_of(S_FETCH, OP_RTYPE, 6'h00);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d, op, funct);
        end
    end

    always_comb begin
        alu_result = 32'd0;
        case (ctrl_q.alu_control)
            ALU_ADD: alu_result = bus.srcA + bus.srcB;
            ALU_SUB: alu_result = bus.srcA - bus.srcB;
            ALU_AND: alu_result = bus.srcA & bus.srcB;
            ALU_OR:  alu_result = bus.srcA | bus.srcB;
            ALU_XOR: alu_result = bus.srcA ^ bus.srcB;
            ALU_NOR: alu_result = ~(bus.srcA | bus.srcB);
            ALU_SLT: alu_result = {31'd0, ($signed(bus.srcA) < $signed(bus.srcB))};
            ALU_SLL: alu_result = bus.srcA << bus.srcB[4:0];
            default: alu_result = 32'd0;
        endcase
    end

    assign bus.ALUResult  = alu_result;
    assign bus.zero       = (alu_result == 32'd0);
    assign bus.pcPlus4    = bus.pcQ + 32'd4;
    assign bus.pcBranch   = bus.pcQ + {{14{imm[15]}}, imm, 2'b00};
    assign bus.ALUControl = ctrl_q.alu_control;
    assign bus.state      = state_q;

    // The reset value mirrors FETCH so the first cycle after release fetches,
    // but architectural writes must be held off while reset is still asserted.
    assign bus.PCWrite        = ctrl_q.pc_write & reset_n;
    assign bus.IRWrite        = ctrl_q.ir_write & reset_n;
    assign bus.memWrite       = ctrl_q.mem_write & reset_n;
    assign bus.regWriteEnable = ctrl_q.reg_write_enable & reset_n;
    assign bus.pcEnable       = (ctrl_q.pc_write | (ctrl_q.branch_enable & bus.zero)) & reset_n;

    assign bus.memToReg     = ctrl_q.mem_to_reg;
    assign bus.branchEnable = ctrl_q.branch_enable;
    assign bus.ALUSrc       = ctrl_q.alu_src;
    assign bus.regDst       = ctrl_q.reg_dst;
    assign bus.jump         = ctrl_q.jump;
    assign bus.jumpReg      = ctrl_q.jump_reg;
    assign bus.IorD         = ctrl_q.ior_d;
    assign bus.ALUSrcA      = ctrl_q.alu_src_a;
    assign bus.ALUSrcB      = ctrl_q.alu_src_b;

endmodule

// File: tb/tb_multicycle_control_alu.sv
// Purpose: self-checking bench for multicycle_control_alu (directed scenarios plus random instruction stream).
// Latency: checks every FSM cycle, sampling 1-2 time units after the rising edge.
// Backpressure: none; the bench holds instr/operands stable for a whole instruction.
module tb_multicycle_control_alu;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   tests   = 0;
    int   fails   = 0;

    multicycle_control_alu_if bus ();

    multicycle_control_alu dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_JR = 3, C_BEQ = 4,
                   C_ADDI = 5, C_J = 6, C_JAL = 7, C_OTHER = 8;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Instruction class from the opcode/funct tables.
    function automatic int cls(input logic [31:0] ins);
        case (ins[31:26])
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h00:   return (ins[5:0] == 6'h08) ? C_JR : C_R;
            6'h04:   return C_BEQ;
            6'h08:   return C_ADDI;
            6'h02:   return C_J;
            6'h03:   return C_JAL;
            default: return C_OTHER;
        endcase
    endfunction

    function automatic int len_of(input int c);
        case (c)
            C_LW:                    return 5;
            C_SW, C_R, C_ADDI:       return 4;
            C_JR, C_BEQ, C_J, C_JAL: return 3;
            default:                 return 2;
        endcase
    endfunction

    // State visited at step k of an instruction of class c.
    function automatic int path_state(input int c, input int k);
        int p[5];
        p = '{0, 1, 0, 0, 0};
        case (c)
            C_LW:   p = '{0, 1, 2, 3, 4};
            C_SW:   p = '{0, 1, 2, 5, 0};
            C_R:    p = '{0, 1, 6, 7, 0};
            C_ADDI: p = '{0, 1, 9, 10, 0};
            C_BEQ:  p = '{0, 1, 8, 0, 0};
            C_J:    p = '{0, 1, 11, 0, 0};
            C_JAL:  p = '{0, 1, 11, 0, 0};
            C_JR:   p = '{0, 1, 12, 0, 0};
            default: p = '{0, 1, 0, 0, 0};
        endcase
        return p[k];
    endfunction

    function automatic logic [31:0] ref_alu(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00:   return a << (b % 32);
            default: return a + b;
        endcase
    endfunction

    task automatic test_reset();
        #1 reset_n = 1'b0;
        bus.instr = 32'hFC000000; bus.srcA = 32'd0; bus.srcB = 32'd0; bus.pcQ = 32'd0;
        #1;
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
        tests++; if ({bus.PCWrite, bus.pcEnable, bus.IRWrite, bus.memWrite, bus.regWriteEnable} !== 5'b0) begin
            fails++; $display("FAIL reset_strobes: got %b expected 00000",
                {bus.PCWrite, bus.pcEnable, bus.IRWrite, bus.memWrite, bus.regWriteEnable}); end
        tick(); tick();
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL reset_hold_state: got %0d expected 0", bus.state); end
        reset_n = 1'b1;
        #1;
        tests++; if ({bus.PCWrite, bus.IRWrite} !== 2'b11) begin fails++; $display("FAIL fetch_after_reset: got %b expected 11", {bus.PCWrite, bus.IRWrite}); end
        tick();
        tests++; if (bus.state !== 4'd1) begin fails++; $display("FAIL first_edge_decode: got %0d expected 1", bus.state); end
        tick();
        // Now abandon a lw while in MEMADR.
        bus.instr = 32'h8C220004;
        #1 tick(); tick();
        tests++; if (bus.state !== 4'd2 || bus.ALUSrcB !== 1'b1) begin fails++; $display("FAIL reach_memadr: got state %0d srcb %b expected 2 1", bus.state, bus.ALUSrcB); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL async_reset_state: got %0d expected 0", bus.state); end
        tests++; if ({bus.PCWrite, bus.pcEnable, bus.IRWrite, bus.memWrite, bus.regWriteEnable} !== 5'b0) begin
            fails++; $display("FAIL async_reset_strobes: got %b expected 00000",
                {bus.PCWrite, bus.pcEnable, bus.IRWrite, bus.memWrite, bus.regWriteEnable}); end
        tick();
        tests++; if ({bus.state, bus.PCWrite, bus.pcEnable, bus.IRWrite, bus.memWrite, bus.regWriteEnable} !== 9'b0) begin
            fails++; $display("FAIL reset_held_edge: got %b expected 0", {bus.state, bus.PCWrite, bus.pcEnable, bus.IRWrite, bus.memWrite, bus.regWriteEnable}); end
        reset_n = 1'b1;
        bus.instr = 32'hFC000000;
        tick();
        tests++; if (bus.state !== 4'd1) begin fails++; $display("FAIL release_decode: got %0d expected 1", bus.state); end
        tick();
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL illegal_back_fetch: got %0d expected 0", bus.state); end
    endtask

    task automatic test_add();
        bus.instr = 32'h00221820; bus.srcA = 32'd7; bus.srcB = 32'd5;
        #1;
        tick();
        tests++; if (bus.state !== 4'd1) begin fails++; $display("FAIL add_decode: got %0d expected 1", bus.state); end
        tick();
        tests++; if (bus.state !== 4'd6 || bus.ALUResult !== 32'd12) begin fails++; $display("FAIL add_execute: got state %0d res %0d expected 6 12", bus.state, bus.ALUResult); end
        tick();
        tests++; if (bus.state !== 4'd7 || {bus.regDst, bus.regWriteEnable} !== 2'b11) begin
            fails++; $display("FAIL add_aluwb: got state %0d dst/we %b expected 7 11", bus.state, {bus.regDst, bus.regWriteEnable}); end
        tick();
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL add_end: got %0d expected 0", bus.state); end
    endtask

    task automatic test_lw_sw();
        int seq_lw[6] = '{0, 1, 2, 3, 4, 0};
        int seq_sw[5] = '{0, 1, 2, 5, 0};
        bus.instr = 32'h8C220004;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            tests++; if (bus.state !== 4'(seq_lw[k])) begin fails++; $display("FAIL lw_seq[%0d]: got %0d expected %0d", k, bus.state, seq_lw[k]); end
            if (k == 2) begin tests++; if (bus.ALUSrcB !== 1'b1) begin fails++; $display("FAIL lw_alusrcb: got %b expected 1", bus.ALUSrcB); end end
            if (k == 3) begin tests++; if (bus.IorD !== 1'b1) begin fails++; $display("FAIL lw_iord: got %b expected 1", bus.IorD); end end
            if (k == 4) begin tests++; if (bus.memToReg !== 1'b1) begin fails++; $display("FAIL lw_memtoreg: got %b expected 1", bus.memToReg); end end
        end
        bus.instr = 32'hAC220004;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            tests++; if (bus.state !== 4'(seq_sw[k])) begin fails++; $display("FAIL sw_seq[%0d]: got %0d expected %0d", k, bus.state, seq_sw[k]); end
            if (k == 3) begin tests++; if (bus.memWrite !== 1'b1) begin fails++; $display("FAIL sw_memwrite: got %b expected 1", bus.memWrite); end end
        end
    endtask

    task automatic test_beq();
        bus.instr = 32'h10220003; bus.pcQ = 32'h100; bus.srcA = 32'd9; bus.srcB = 32'd9;
        #1;
        tests++; if (bus.pcPlus4 !== 32'h104 || bus.pcBranch !== 32'h10C) begin
            fails++; $display("FAIL beq_adders: got %h %h expected 104 10c", bus.pcPlus4, bus.pcBranch); end
        tick(); tick();
        tests++; if (bus.state !== 4'd8 || bus.zero !== 1'b1 || bus.pcEnable !== 1'b1) begin
            fails++; $display("FAIL beq_taken: got state %0d zero %b pce %b expected 8 1 1", bus.state, bus.zero, bus.pcEnable); end
        tick();
        bus.srcB = 32'd8;
        #1;
        tick(); tick();
        tests++; if (bus.state !== 4'd8 || bus.pcEnable !== 1'b0) begin
            fails++; $display("FAIL beq_not_taken: got state %0d pce %b expected 8 0", bus.state, bus.pcEnable); end
        tick();
    endtask

    task automatic test_alu_corners();
        logic [31:0] ins_t[4] = '{32'h00221822, 32'h0022182A, 32'h00221820, 32'h00221827};
        logic [31:0] a_t[4]   = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [31:0] b_t[4]   = '{32'd7, 32'd1, 32'd1, 32'd0};
        logic [31:0] r_t[4]   = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            bus.instr = ins_t[i]; bus.srcA = a_t[i]; bus.srcB = b_t[i];
            #1 tick(); tick();
            tests++; if (bus.state !== 4'd6 || bus.ALUResult !== r_t[i] || bus.zero !== (r_t[i] == 32'd0)) begin
                fails++; $display("FAIL alu_corner[%0d]: got state %0d res %h zero %b expected 6 %h", i, bus.state, bus.ALUResult, bus.zero, r_t[i]); end
            tick(); tick();
        end
    endtask

    task automatic test_jump();
        bus.instr = 32'h0C000010;
        #1 tick(); tick();
        tests++; if (bus.state !== 4'd11 || {bus.jump, bus.PCWrite, bus.regWriteEnable} !== 3'b111) begin
            fails++; $display("FAIL jal: got state %0d j/pcw/we %b expected 11 111", bus.state, {bus.jump, bus.PCWrite, bus.regWriteEnable}); end
        tick();
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL jal_end: got %0d expected 0", bus.state); end
        bus.instr = 32'hFC000000;
        #1 tick();
        tests++; if (bus.state !== 4'd1) begin fails++; $display("FAIL illegal_decode: got %0d expected 1", bus.state); end
        tick();
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL illegal_fetch: got %0d expected 0", bus.state); end
    endtask

    task automatic test_random_stream();
        logic [5:0]  ops[8]    = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h03, 6'h3F};
        logic [5:0]  fns[9]    = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h08};
        logic [31:0] ins, a, b, e_alu, e_branch;
        logic        e_zero, e_pcw, last;
        int          c, len;
        for (int n = 0; n < 80; n++) begin
            ins = $urandom;
            ins[31:26] = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) != 0) ins[5:0] = fns[$urandom_range(0, 8)];
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom);
            bus.instr = ins; bus.srcA = a; bus.srcB = b; bus.pcQ = $urandom;
            c   = cls(ins);
            len = len_of(c);
            #1;
            e_branch = bus.pcQ + 32'($signed(ins[15:0]) * 4);
            tests++; if (bus.pcPlus4 !== bus.pcQ + 32'd4 || bus.pcBranch !== e_branch) begin
                fails++; $display("FAIL rnd_adders[%0d]: got %h %h expected %h %h", n, bus.pcPlus4, bus.pcBranch, bus.pcQ + 32'd4, e_branch); end
            for (int k = 0; k < len; k++) begin
                if (k > 0) tick();
                last  = (k == len - 1);
                e_alu = (c == C_R && k == 2) ? ref_alu(ins[5:0], a, b) :
                        (c == C_BEQ && k == 2) ? a - b : a + b;
                e_zero = (e_alu == 32'd0);
                e_pcw  = (k == 0) || (last && (c == C_J || c == C_JAL || c == C_JR));
                tests++; if (bus.state !== 4'(path_state(c, k))) begin
                    fails++; $display("FAIL rnd_state[%0d/%0d] instr %h: got %0d expected %0d", n, k, ins, bus.state, path_state(c, k)); end
                tests++; if (bus.ALUResult !== e_alu || bus.zero !== e_zero) begin
                    fails++; $display("FAIL rnd_alu[%0d/%0d] instr %h: got %h/%b expected %h/%b", n, k, ins, bus.ALUResult, bus.zero, e_alu, e_zero); end
                tests++; if (bus.regWriteEnable !== (last && (c == C_LW || c == C_R || c == C_ADDI || c == C_JAL))
                          || bus.memWrite !== (last && c == C_SW) || bus.IRWrite !== (k == 0) || bus.PCWrite !== e_pcw
                          || bus.pcEnable !== (e_pcw || (c == C_BEQ && k == 2 && e_zero))) begin
                    fails++; $display("FAIL rnd_strobes[%0d/%0d] instr %h: got we %b mw %b irw %b pcw %b pce %b",
                        n, k, ins, bus.regWriteEnable, bus.memWrite, bus.IRWrite, bus.PCWrite, bus.pcEnable); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_sw();
        test_beq();
        test_alu_corners();
        test_jump();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
